watch_char_gen: RTL and testbench



---
 rtl/watch_pkg.sv | 37 +++
 rtl/bcd2_counter.sv | 38 +++
 rtl/watch_char_gen.sv | 147 ++++++++++++++
 tb/tb_watch_char_gen.sv | 223 ++++++++++++++++++++++
 4 files changed

// File: rtl/watch_pkg.sv
// Shared constants for the watch character generator.
// Mode encodings, ASCII codes, line-1 field positions and line-2 text.
package watch_pkg;

    localparam logic [1:0] RUN   = 2'd0;
    localparam logic [1:0] SET_H = 2'd1;
    localparam logic [1:0] SET_M = 2'd2;
    localparam logic [1:0] SET_S = 2'd3;

    localparam logic [7:0] ASC_0   = 8'h30;
    localparam logic [7:0] ASC_SP  = 8'h20;
    localparam logic [7:0] ASC_COL = 8'h3A;

    localparam logic [3:0] IDX_H = 4'd8;
    localparam logic [3:0] IDX_M = 4'd11;
    localparam logic [3:0] IDX_S = 4'd14;

    // Sixteen characters of line 2 for a given mode, space padded
    function automatic logic [127:0] mode_text(input logic [1:0] m);
        logic [127:0] t;
        t = "RUN             ";
        case (m)
            SET_H:   t = "SET HOUR        ";
            SET_M:   t = "SET MIN         ";
            SET_S:   t = "SET SEC         ";
            default: t = "RUN             ";
        endcase
        return t;
    endfunction

    // One BCD digit as ASCII, or a space when blanked
    function automatic logic [7:0] digit(input logic [3:0] d,
                                         input logic blank);
        return blank ? ASC_SP : (ASC_0 | {4'h0, d});
    endfunction

endpackage

// File: rtl/bcd2_counter.sv
// Two-digit BCD counter that wraps to 00 after MAX_T/MAX_O.
// carry is high in the cycle an increment causes the wrap.
module bcd2_counter #(
    parameter logic [3:0] MAX_T = 4'd5,
    parameter logic [3:0] MAX_O = 4'd9
) (
    input  logic       clk,
    input  logic       rst,
    input  logic       inc,
    output logic [3:0] tens,
    output logic [3:0] ones,
    output logic       carry
);

    logic at_max;

    assign at_max = (tens == MAX_T) && (ones == MAX_O);
    assign carry  = inc && at_max;

    // Step the two digits on inc, wrapping at the limit
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            tens <= 4'd0;
            ones <= 4'd0;
        end else if (inc) begin
            if (at_max) begin
                tens <= 4'd0;
                ones <= 4'd0;
            end else if (ones == 4'd9) begin
                tens <= tens + 4'd1;
                ones <= 4'd0;
            end else begin
                ones <= ones + 4'd1;
            end
        end
    end

endmodule

// File: rtl/watch_char_gen.sv
// 24-hour BCD watch with set mode, blinking field and LCD text lookup.
// Also paces the LCD engine with a periodic en_clk strobe.
module watch_char_gen
    import watch_pkg::*;
#(
    parameter int CLK_HZ = 50000000,
    parameter int EN_DIV = 50000
) (
    input  logic       clk,
    input  logic       rst,
    input  logic       btn_mode,
    input  logic       btn_inc,
    input  logic [4:0] index_char,
    output logic [7:0] data_char,
    output logic       en_clk,
    output logic       sec_tick
);

    localparam int PW = $clog2(CLK_HZ);
    localparam int EW = $clog2(EN_DIV);
    localparam logic [PW-1:0] PRE_MAX = PW'(CLK_HZ - 1);
    localparam logic [PW-1:0] BLK_MAX = PW'(CLK_HZ / 2 - 1);
    localparam logic [EW-1:0] EN_MAX  = EW'(EN_DIV - 1);

    logic [1:0]    mode;
    logic [PW-1:0] pre;
    logic [PW-1:0] blk_cnt;
    logic          blink_on;
    logic [EW-1:0] en_cnt;
    logic          pre_wrap;
    logic          acc_inc;
    logic          s_inc, m_inc, h_inc;
    logic          s_c, m_c, h_carry_unused;
    logic [3:0]    h_t, h_o, m_t, m_o, s_t, s_o;
    logic [3:0]    pos;
    logic [127:0]  line2;
    logic          blank_h, blank_m, blank_s;

    assign pre_wrap = (mode == RUN) && (pre == PRE_MAX);
    assign acc_inc  = btn_inc && !btn_mode && (mode != RUN);

    assign s_inc = pre_wrap || (acc_inc && mode == SET_S);
    assign m_inc = (pre_wrap && s_c) || (acc_inc && mode == SET_M);
    assign h_inc = (pre_wrap && m_c) || (acc_inc && mode == SET_H);

    assign en_clk = (en_cnt == EN_MAX);

    bcd2_counter #(.MAX_T(4'd5), .MAX_O(4'd9)) u_sec (
        .clk(clk), .rst(rst), .inc(s_inc),
        .tens(s_t), .ones(s_o), .carry(s_c)
    );

    bcd2_counter #(.MAX_T(4'd5), .MAX_O(4'd9)) u_min (
        .clk(clk), .rst(rst), .inc(m_inc),
        .tens(m_t), .ones(m_o), .carry(m_c)
    );

    bcd2_counter #(.MAX_T(4'd2), .MAX_O(4'd3)) u_hr (
        .clk(clk), .rst(rst), .inc(h_inc),
        .tens(h_t), .ones(h_o), .carry(h_carry_unused)
    );

    // Free-running LCD step divider
    always_ff @(posedge clk or negedge rst) begin
        if (!rst)
            en_cnt <= '0;
        else if (en_clk)
            en_cnt <= '0;
        else
            en_cnt <= en_cnt + EW'(1);
    end

    // One-second prescaler; parked at 0 outside RUN and on mode change
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            pre      <= '0;
            sec_tick <= 1'b0;
        end else begin
            sec_tick <= pre_wrap;
            if (mode != RUN || btn_mode || pre_wrap)
                pre <= '0;
            else
                pre <= pre + PW'(1);
        end
    end

    // Mode sequence RUN -> SET_H -> SET_M -> SET_S -> RUN
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            mode <= RUN;
        end else if (btn_mode) begin
            case (mode)
                RUN:     mode <= SET_H;
                SET_H:   mode <= SET_M;
                SET_M:   mode <= SET_S;
                default: mode <= RUN;
            endcase
        end
    end

    // Half-second blink of the selected field, restarted on any edit
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            blk_cnt  <= '0;
            blink_on <= 1'b1;
        end else if (btn_mode || acc_inc || mode == RUN) begin
            blk_cnt  <= '0;
            blink_on <= 1'b1;
        end else if (blk_cnt == BLK_MAX) begin
            blk_cnt  <= '0;
            blink_on <= ~blink_on;
        end else begin
            blk_cnt  <= blk_cnt + PW'(1);
        end
    end

    assign pos     = index_char[3:0];
    assign blank_h = !blink_on && mode == SET_H;
    assign blank_m = !blink_on && mode == SET_M;
    assign blank_s = !blink_on && mode == SET_S;

    // Character lookup for the requested screen position
    always_comb begin
        line2     = mode_text(mode);
        data_char = ASC_SP;
        if (index_char[4]) begin
            data_char = line2[{~pos, 3'b000} +: 8];
        end else begin
            case (pos)
                4'd0:            data_char = "T";
                4'd1:            data_char = "I";
                4'd2:            data_char = "M";
                4'd3:            data_char = "E";
                IDX_H:           data_char = digit(h_t, blank_h);
                IDX_H + 4'd1:    data_char = digit(h_o, blank_h);
                IDX_M - 4'd1:    data_char = ASC_COL;
                IDX_M:           data_char = digit(m_t, blank_m);
                IDX_M + 4'd1:    data_char = digit(m_o, blank_m);
                IDX_S - 4'd1:    data_char = ASC_COL;
                IDX_S:           data_char = digit(s_t, blank_s);
                IDX_S + 4'd1:    data_char = digit(s_o, blank_s);
                default:         data_char = ASC_SP;
            endcase
        end
    end

endmodule

// File: tb/tb_watch_char_gen.sv
// Scoreboard bench for watch_char_gen with CLK_HZ=10, EN_DIV=4.
// Stimulus queues expected values; a monitor pops and compares.
module tb_watch_char_gen;

    logic       clk;
    logic       rst;
    logic       btn_mode;
    logic       btn_inc;
    logic [4:0] index_char;
    logic [7:0] data_char;
    logic       en_clk;
    logic       sec_tick;

    typedef struct {
        string name;
        int    kind;
        int    exp;
    } chk_t;

    chk_t q[$];
    event probe;
    int   n_chk;
    int   n_pass;
    int   tick_cnt;
    logic tick_clr;

    watch_char_gen #(.CLK_HZ(10), .EN_DIV(4)) dut (
        .clk(clk),
        .rst(rst),
        .btn_mode(btn_mode),
        .btn_inc(btn_inc),
        .index_char(index_char),
        .data_char(data_char),
        .en_clk(en_clk),
        .sec_tick(sec_tick)
    );

    initial begin
        clk = 1'b0;
        forever #100 clk = ~clk;
    end

    initial begin
        #2000000;
        $display("FAIL timeout: bench did not finish");
        $fatal(1);
    end

    // Count DUT second ticks between clears
    always @(negedge clk) begin
        if (tick_clr)
            tick_cnt <= 0;
        else if (sec_tick)
            tick_cnt <= tick_cnt + 1;
    end

    // Monitor: compare DUT outputs against queued expectations
    initial begin
        n_chk  = 0;
        n_pass = 0;
        forever begin
            @(probe);
            while (q.size() > 0) begin
                chk_t c;
                int act;
                c = q.pop_front();
                case (c.kind)
                    0:       act = int'(data_char);
                    1:       act = int'(en_clk);
                    2:       act = int'(sec_tick);
                    default: act = tick_cnt;
                endcase
                n_chk++;
                if (act == c.exp)
                    n_pass++;
                else
                    $display("FAIL %s: got %0h want %0h",
                             c.name, act, c.exp);
            end
        end
    end

    task automatic step();
        @(posedge clk);
        #2;
    endtask

    task automatic chk(input int kind, input int exp, input string name);
        q.push_back('{name, kind, exp});
        ->probe;
        #1;
    endtask

    task automatic chk_str(input int start, input string s,
                           input string name);
        for (int i = 0; i < s.len(); i++) begin
            index_char = 5'(start + i);
            #1;
            chk(0, int'(s[i]), $sformatf("%s[%0d]", name, start + i));
        end
    endtask

    task automatic press(input logic m, input logic i);
        btn_mode = m;
        btn_inc  = i;
        step();
        btn_mode = 1'b0;
        btn_inc  = 1'b0;
    endtask

    task automatic inc_n(input int n);
        repeat (n) press(1'b0, 1'b1);
    endtask

    initial begin
        rst        = 1'b0;
        btn_mode   = 1'b0;
        btn_inc    = 1'b0;
        index_char = 5'd0;
        tick_clr   = 1'b1;
        step();
        step();
        chk(1, 0, "reset en_clk");
        chk(2, 0, "reset sec_tick");
        chk_str(16, "R", "reset line2");

        // 1: text after reset, en_clk cadence, first second tick
        rst = 1'b1;
        chk_str(0, "TIME    00:00:00", "t1 line1");
        chk_str(16, "RUN             ", "t1 line2");
        for (int k = 1; k <= 12; k++) begin
            step();
            chk(1, (k % 4 == 3) ? 1 : 0, $sformatf("t1 en_clk c%0d", k));
            chk(2, (k == 10) ? 1 : 0, $sformatf("t1 sec_tick c%0d", k));
        end

        // 2: set 23:59:58 and roll over midnight
        press(1'b1, 1'b0);
        inc_n(23);
        press(1'b1, 1'b0);
        inc_n(59);
        press(1'b1, 1'b0);
        inc_n(57);
        press(1'b1, 1'b0);
        chk_str(8, "23:59:58", "t2 set");
        chk_str(16, "RUN", "t2 mode");
        tick_clr = 1'b1;
        step();
        tick_clr = 1'b0;
        repeat (19) step();
        @(negedge clk);
        #1;
        chk(3, 2, "t2 tick count");
        chk_str(8, "00:00:00", "t2 wrap");

        // 3: hours wrap in SET_H without carry or ticks
        press(1'b1, 1'b0);
        chk_str(16, "SET HOUR        ", "t3 line2");
        tick_clr = 1'b1;
        press(1'b0, 1'b1);
        tick_clr = 1'b0;
        inc_n(22);
        chk_str(8, "23", "t3 hours 23");
        press(1'b0, 1'b1);
        chk_str(8, "00:00:00", "t3 hours wrap");
        @(negedge clk);
        #1;
        chk(3, 0, "t3 no tick");

        // 4: minutes blink in SET_M; inc forces visible
        press(1'b1, 1'b0);
        chk_str(11, "0", "t4 enter");
        for (int k = 1; k <= 10; k++) begin
            step();
            chk_str(11, (k >= 5 && k < 10) ? " " : "0",
                    $sformatf("t4 blink c%0d", k));
        end
        repeat (5) step();
        chk_str(11, "  ", "t4 blank");
        press(1'b0, 1'b1);
        chk_str(11, "01", "t4 inc shows");
        chk_str(8, "00", "t4 hours kept");

        // 5: btn_mode beats btn_inc
        press(1'b1, 1'b0);
        press(1'b1, 1'b0);
        press(1'b1, 1'b0);
        chk_str(16, "SET HOUR", "t5 in set_h");
        press(1'b1, 1'b1);
        chk_str(16, "SET MIN ", "t5 mode");
        chk_str(8, "00:01", "t5 hours kept");

        // 6: reset from SET_S at 12:34:56
        inc_n(33);
        press(1'b1, 1'b0);
        inc_n(56);
        press(1'b1, 1'b0);
        press(1'b1, 1'b0);
        inc_n(12);
        press(1'b1, 1'b0);
        press(1'b1, 1'b0);
        chk_str(8, "12:34:56", "t6 time");
        chk_str(16, "SET SEC", "t6 mode");
        rst = 1'b0;
        #1;
        chk(1, 0, "t6 en_clk");
        chk(2, 0, "t6 sec_tick");
        chk_str(16, "RUN ", "t6 line2");
        chk_str(8, "00:00:00", "t6 time");
        step();
        chk(1, 0, "t6 en_clk held");
        rst = 1'b1;

        #5;
        if (q.size() != 0) begin
            n_chk++;
            $display("FAIL drain: got %0d want 0 pending", q.size());
        end
        $display("%0d/%0d checks passed", n_pass, n_chk);
        $finish;
    end

endmodule
